// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave register file: NUM_REGS word registers with byte strobes,
// read-only and privileged write masks, SLVERR/DECERR responses, optional read pipeline.
module axil_reg_slave #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 16,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int NUM_REGS        = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK   = '0,
  parameter logic [NUM_REGS-1:0] PRIV_MASK = '0,
  parameter bit PIPELINE_OUTPUT = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready
);

  localparam int OFS_W = $clog2(STRB_WIDTH);
  localparam int IDX_W = ADDR_WIDTH - OFS_W;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Holds the readies low until the first clock edge after reset is released.
  logic rdy_en;

  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [2:0]            aw_prot_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;

  logic aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [2:0]            wr_prot;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [NUM_REGS-1:0]   wr_sel, rd_sel;
  logic [1:0]            wr_resp, rd_resp;
  logic                  wr_ok;
  logic [DATA_WIDTH-1:0] rd_val;

  logic                  p_valid;
  logic [DATA_WIDTH-1:0] p_data;
  logic [1:0]            p_resp;

  assign s_axil_awready = rdy_en && !aw_held && !s_axil_bvalid;
  assign s_axil_wready  = rdy_en && !w_held && !s_axil_bvalid;
  assign s_axil_arready = rdy_en && !s_axil_rvalid && !p_valid;

  assign aw_hs  = s_axil_awvalid && s_axil_awready;
  assign w_hs   = s_axil_wvalid && s_axil_wready;
  assign ar_hs  = s_axil_arvalid && s_axil_arready;
  assign commit = (aw_held || aw_hs) && (w_held || w_hs);

  assign wr_addr = aw_held ? aw_addr_q : s_axil_awaddr;
  assign wr_prot = aw_held ? aw_prot_q : s_axil_awprot;
  assign wr_data = w_held ? w_data_q : s_axil_wdata;
  assign wr_strb = w_held ? w_strb_q : s_axil_wstrb;
  assign wr_idx  = wr_addr[ADDR_WIDTH-1:OFS_W];
  assign rd_idx  = s_axil_araddr[ADDR_WIDTH-1:OFS_W];

  // One-hot selects avoid indexing past NUM_REGS; an all-zero select is a decode error.
  always_comb begin
    wr_sel = '0;
    rd_sel = '0;
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_sel[i] = (wr_idx == IDX_W'(i));
      rd_sel[i] = (rd_idx == IDX_W'(i));
      if (rd_sel[i]) rd_val = regs[i];
    end
  end

  always_comb begin
    wr_resp = RESP_OKAY;
    if (wr_sel == '0)
      wr_resp = RESP_DECERR;
    else if ((wr_sel & RO_MASK) != '0)
      wr_resp = RESP_SLVERR;
    else if (((wr_sel & PRIV_MASK) != '0) && !wr_prot[0])
      wr_resp = RESP_SLVERR;
    wr_ok   = (wr_resp == RESP_OKAY);
    rd_resp = (rd_sel == '0) ? RESP_DECERR : RESP_OKAY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en        <= 1'b0;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_addr_q     <= '0;
      aw_prot_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      s_axil_bvalid <= 1'b0;
      s_axil_bresp  <= RESP_OKAY;
    end else begin
      rdy_en <= 1'b1;
      if (s_axil_bvalid && s_axil_bready) s_axil_bvalid <= 1'b0;
      if (commit) begin
        aw_held       <= 1'b0;
        w_held        <= 1'b0;
        s_axil_bvalid <= 1'b1;
        s_axil_bresp  <= wr_resp;
      end else begin
        if (aw_hs) begin
          aw_held   <= 1'b1;
          aw_addr_q <= s_axil_awaddr;
          aw_prot_q <= s_axil_awprot;
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= s_axil_wdata;
          w_strb_q <= s_axil_wstrb;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit && wr_ok) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_sel[i]) begin
          for (int b = 0; b < STRB_WIDTH; b++) begin
            if (wr_strb[b]) regs[i][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  // Read path: reg samples are taken before any same-edge write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_axil_rvalid <= 1'b0;
      s_axil_rdata  <= '0;
      s_axil_rresp  <= RESP_OKAY;
      p_valid       <= 1'b0;
      p_data        <= '0;
      p_resp        <= RESP_OKAY;
    end else begin
      if (s_axil_rvalid && s_axil_rready) s_axil_rvalid <= 1'b0;
      if (!PIPELINE_OUTPUT) begin
        if (ar_hs) begin
          s_axil_rvalid <= 1'b1;
          s_axil_rdata  <= rd_val;
          s_axil_rresp  <= rd_resp;
        end
      end else begin
        if (ar_hs) begin
          p_valid <= 1'b1;
          p_data  <= rd_val;
          p_resp  <= rd_resp;
        end
        if (p_valid && (!s_axil_rvalid || s_axil_rready)) begin
          p_valid       <= 1'b0;
          s_axil_rvalid <= 1'b1;
          s_axil_rdata  <= p_data;
          s_axil_rresp  <= p_resp;
        end
      end
    end
  end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed bench for axil_reg_slave: unpipelined instance with RO/PRIV masks,
// plus a pipelined instance used for read-latency checks.
module tb_axil_reg_slave;

  logic        clk = 0;
  logic        rst = 1;
  logic [15:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1;
  logic [15:0] araddr = '0;
  logic        arvalid = 0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1;

  logic        p_awready, p_wready, p_bvalid, p_arready, p_rvalid;
  logic [1:0]  p_bresp, p_rresp;
  logic [31:0] p_rdata;
  logic [15:0] p_araddr = '0;
  logic        p_arvalid = 0;
  logic        p_rready = 1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  axil_reg_slave #(
    .RO_MASK(16'h0008), .PRIV_MASK(16'h0020), .PIPELINE_OUTPUT(1'b0)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid),
    .s_axil_awready(awready), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
    .s_axil_wvalid(wvalid), .s_axil_wready(wready), .s_axil_bresp(bresp),
    .s_axil_bvalid(bvalid), .s_axil_bready(bready), .s_axil_araddr(araddr),
    .s_axil_arprot(3'b000), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid),
    .s_axil_rready(rready)
  );

  axil_reg_slave #(.PIPELINE_OUTPUT(1'b1)) dut_p (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(16'h0000), .s_axil_awprot(3'b000), .s_axil_awvalid(1'b0),
    .s_axil_awready(p_awready), .s_axil_wdata(32'h0), .s_axil_wstrb(4'h0),
    .s_axil_wvalid(1'b0), .s_axil_wready(p_wready), .s_axil_bresp(p_bresp),
    .s_axil_bvalid(p_bvalid), .s_axil_bready(1'b1), .s_axil_araddr(p_araddr),
    .s_axil_arprot(3'b000), .s_axil_arvalid(p_arvalid), .s_axil_arready(p_arready),
    .s_axil_rdata(p_rdata), .s_axil_rresp(p_rresp), .s_axil_rvalid(p_rvalid),
    .s_axil_rready(p_rready)
  );

  // Drives AW and W together; lat = cycles from last handshake until bvalid seen.
  task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [2:0] p, output logic [1:0] resp, output int lat);
    bit a_now, w_now, aw_done, w_done;
    int n;
    aw_done = 0; w_done = 0; n = 0; resp = 2'bxx;
    awaddr = a; awprot = p; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    while (!(aw_done && w_done) && n < 50) begin
      @(negedge clk);
      a_now = awvalid && awready;
      w_now = wvalid && wready;
      @(posedge clk); #1;
      if (a_now) begin awvalid = 0; aw_done = 1; end
      if (w_now) begin wvalid = 0; w_done = 1; end
      n++;
    end
    awvalid = 0; wvalid = 0;
    lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (bvalid) begin resp = bresp; break; end
    end
    if (n >= 50 || lat >= 50) begin
      total++; bad++;
      $display("FAIL write_timeout addr=%h handshakes=%0d bwait=%0d", a, n, lat);
    end
    @(posedge clk); #1;
  endtask

  // sel=0 reads the unpipelined instance, sel=1 the pipelined one.
  task automatic do_read(input bit sel, input logic [15:0] a,
                         output logic [31:0] d, output logic [1:0] resp, output int lat);
    bit hs;
    int n;
    hs = 0; n = 0; d = 'x; resp = 'x;
    if (sel) begin p_araddr = a; p_arvalid = 1; end
    else begin araddr = a; arvalid = 1; end
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = sel ? p_arready : arready;
      @(posedge clk); #1;
      n++;
    end
    arvalid = 0; p_arvalid = 0;
    lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (sel ? p_rvalid : rvalid) begin
        d = sel ? p_rdata : rdata;
        resp = sel ? p_rresp : rresp;
        break;
      end
    end
    if (n >= 50 || lat >= 50) begin
      total++; bad++;
      $display("FAIL read_timeout addr=%h arwait=%0d rwait=%0d", a, n, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=00000", {awready, wready, arready, bvalid, rvalid});
    end
    total++;
    if ({bresp, rresp, rdata} !== 36'h0) begin
      bad++; $display("FAIL reset_data got bresp=%b rresp=%b rdata=%h want 0", bresp, rresp, rdata);
    end
    rst = 0;
    #1;
    total++;
    if ({awready, wready, arready} !== 3'b000) begin
      bad++; $display("FAIL ready_before_edge got=%b want=000", {awready, wready, arready});
    end
    @(posedge clk); #1;
    total++;
    if ({awready, wready, arready} !== 3'b111) begin
      bad++; $display("FAIL ready_after_edge got=%b want=111", {awready, wready, arready});
    end
  endtask

  task automatic test_basic();
    logic [1:0] r; logic [31:0] d; int lat;
    do_write(16'h0004, 32'hDEADBEEF, 4'hF, 3'b000, r, lat);
    total++;
    if (r !== 2'b00 || lat !== 1) begin
      bad++; $display("FAIL basic_write got resp=%b lat=%0d want resp=00 lat=1", r, lat);
    end
    do_read(0, 16'h0004, d, r, lat);
    total++;
    if (d !== 32'hDEADBEEF || r !== 2'b00 || lat !== 1) begin
      bad++; $display("FAIL basic_read got %h/%b/%0d want deadbeef/00/1", d, r, lat);
    end
    do_read(0, 16'h0006, d, r, lat);
    total++;
    if (d !== 32'hDEADBEEF || r !== 2'b00) begin
      bad++; $display("FAIL offset_ignored got %h/%b want deadbeef/00", d, r);
    end
    do_write(16'h003C, 32'h0F0F0F0F, 4'hF, 3'b000, r, lat);
    do_read(0, 16'h003C, d, r, lat);
    total++;
    if (d !== 32'h0F0F0F0F || r !== 2'b00) begin
      bad++; $display("FAIL last_reg got %h/%b want 0f0f0f0f/00", d, r);
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] r; logic [31:0] d; int lat;
    do_write(16'h0008, 32'hFFFFFFFF, 4'hF, 3'b000, r, lat);
    wdata = 32'h12345678; wstrb = 4'h3; wvalid = 1;
    @(negedge clk);
    total++;
    if (wready !== 1'b1) begin bad++; $display("FAIL w_first_ready got=%b want=1", wready); end
    @(posedge clk); #1;
    wvalid = 0;
    total++;
    if (wready !== 1'b0 || bvalid !== 1'b0) begin
      bad++; $display("FAIL w_held got wready=%b bvalid=%b want 0 0", wready, bvalid);
    end
    repeat (2) begin @(posedge clk); #1; end
    awaddr = 16'h0008; awprot = 3'b000; awvalid = 1;
    @(negedge clk);
    total++;
    if (awready !== 1'b1) begin bad++; $display("FAIL aw_late_ready got=%b want=1", awready); end
    @(posedge clk); #1;
    awvalid = 0;
    total++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      bad++; $display("FAIL w_first_b got bvalid=%b bresp=%b want 1 00", bvalid, bresp);
    end
    @(posedge clk); #1;
    do_read(0, 16'h0008, d, r, lat);
    total++;
    if (d !== 32'hFFFF5678) begin bad++; $display("FAIL strb_merge got %h want ffff5678", d); end
    do_write(16'h001C, 32'h11111111, 4'hF, 3'b000, r, lat);
    do_write(16'h001C, 32'h22222222, 4'h0, 3'b000, r, lat);
    do_read(0, 16'h001C, d, r, lat);
    total++;
    if (d !== 32'h11111111) begin bad++; $display("FAIL strb_zero got %h want 11111111", d); end
  endtask

  task automatic test_errors();
    logic [1:0] r; logic [31:0] d; int lat;
    do_write(16'h0040, 32'hA5A5A5A5, 4'hF, 3'b001, r, lat);
    total++;
    if (r !== 2'b11) begin bad++; $display("FAIL decerr_write got %b want 11", r); end
    do_read(0, 16'h0040, d, r, lat);
    total++;
    if (d !== 32'h0 || r !== 2'b11) begin
      bad++; $display("FAIL decerr_read got %h/%b want 0/11", d, r);
    end
    do_write(16'h000C, 32'hAAAA5555, 4'hF, 3'b001, r, lat);
    total++;
    if (r !== 2'b10) begin bad++; $display("FAIL ro_write got %b want 10", r); end
    do_read(0, 16'h000C, d, r, lat);
    total++;
    if (d !== 32'h0 || r !== 2'b00) begin bad++; $display("FAIL ro_unchanged got %h/%b want 0/00", d, r); end
    do_write(16'h0014, 32'h13572468, 4'hF, 3'b000, r, lat);
    total++;
    if (r !== 2'b10) begin bad++; $display("FAIL priv_denied got %b want 10", r); end
    do_read(0, 16'h0014, d, r, lat);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL priv_unchanged got %h want 0", d); end
    do_write(16'h0014, 32'h13572468, 4'hF, 3'b001, r, lat);
    total++;
    if (r !== 2'b00) begin bad++; $display("FAIL priv_allowed got %b want 00", r); end
    do_read(0, 16'h0014, d, r, lat);
    total++;
    if (d !== 32'h13572468) begin bad++; $display("FAIL priv_written got %h want 13572468", d); end
  endtask

  task automatic test_backpressure();
    logic [1:0] r; logic [31:0] d; int lat;
    bready = 0;
    do_write(16'h0018, 32'hCAFEF00D, 4'hF, 3'b000, r, lat);
    awvalid = 1; wvalid = 1; awaddr = 16'h0018; wdata = 32'h0BADBAD0; wstrb = 4'hF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({bvalid, bresp, awready, wready} !== 5'b10000) begin
        bad++; $display("FAIL b_stall cyc=%0d got=%b want=10000", i, {bvalid, bresp, awready, wready});
      end
    end
    awvalid = 0; wvalid = 0;
    bready = 1;
    @(posedge clk); #1;
    total++;
    if (bvalid !== 1'b0) begin bad++; $display("FAIL b_release got %b want 0", bvalid); end
    rready = 0;
    do_read(0, 16'h0018, d, r, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (rvalid !== 1'b1 || rdata !== 32'hCAFEF00D || arready !== 1'b0) begin
        bad++; $display("FAIL r_stall cyc=%0d got %b/%h/%b want 1/cafef00d/0", i, rvalid, rdata, arready);
      end
    end
    rready = 1;
    @(posedge clk); #1;
    total++;
    if (rvalid !== 1'b0) begin bad++; $display("FAIL r_release got %b want 0", rvalid); end
    do_read(1, 16'h0000, d, r, lat);
    total++;
    if (d !== 32'h0 || r !== 2'b00 || lat !== 2) begin
      bad++; $display("FAIL pipe_read got %h/%b/%0d want 0/00/2", d, r, lat);
    end
    do_read(1, 16'h0044, d, r, lat);
    total++;
    if (r !== 2'b11 || lat !== 2) begin
      bad++; $display("FAIL pipe_decerr got %b/%0d want 11/2", r, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] r; logic [31:0] d; int lat;
    bready = 0; rready = 0;
    do_write(16'h0020, 32'h55AA55AA, 4'hF, 3'b000, r, lat);
    do_read(0, 16'h0020, d, r, lat);
    @(negedge clk);
    total++;
    if ({bvalid, rvalid} !== 2'b11) begin
      bad++; $display("FAIL pre_reset_valids got=%b want=11", {bvalid, rvalid});
    end
    #2 rst = 1;
    #1;
    total++;
    if ({bvalid, rvalid, awready, arready} !== 4'b0000) begin
      bad++; $display("FAIL async_drop got=%b want=0000", {bvalid, rvalid, awready, arready});
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 0; bready = 1; rready = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({bvalid, rvalid} !== 2'b00) begin
        bad++; $display("FAIL ghost_resp cyc=%0d got=%b want=00", i, {bvalid, rvalid});
      end
    end
    @(posedge clk); #1;
    do_read(0, 16'h0004, d, r, lat);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL cleared_r1 got %h want 0", d); end
    do_read(0, 16'h0014, d, r, lat);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL cleared_r5 got %h want 0", d); end
    do_read(0, 16'h0020, d, r, lat);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL cleared_r8 got %h want 0", d); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_w_before_aw();
    test_errors();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
